// File: rtl/arb_pkg.sv
// Shared definitions for the two-requester round-robin arbiter.
// Holds the FSM state encoding and the mux select polarity used by the
// arbiter and by anything decoding its Select output.
package arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_G1   = 2'd1;
  localparam logic [1:0] ST_G2   = 2'd2;

  localparam logic SEL_CH1 = 1'b1;
  localparam logic SEL_CH2 = 1'b0;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    G1   = ST_G1,
    G2   = ST_G2
  } state_t;

endpackage

// File: rtl/mux_2cross1.sv
// Single-bit 2:1 multiplexer.
// Ports:
//   Input1 - routed to Out when Select=1
//   Input2 - routed to Out when Select=0
//   Select - channel select
//   Out    - selected bit
module mux_2cross1 (
  input  logic Input1,
  input  logic Input2,
  input  logic Select,
  output logic Out
);

  assign Out = Select ? Input1 : Input2;

endmodule

// File: rtl/arb_2cross1_rr.sv
// Round-robin arbiter sharing one WIDTH-bit valid/ready output channel
// between two requesters. The registered Select steers a bitwise 2:1 mux
// datapath; a requester may hold the grant for at most HOLD_MAX
// consecutive beats while the other one is waiting.
// Ports:
//   Clock, Reset_n          - rising-edge clock, async active-low reset
//   Req1/Data1/Ack1         - requester 1 beat request, data, acceptance
//   Req2/Data2/Ack2         - requester 2 beat request, data, acceptance
//   OutValid/OutData/OutReady - downstream valid/ready channel
//   Select                  - registered mux select (1 = channel 1)
//   Grant1/Grant2           - registered grants, mutually exclusive
module arb_2cross1_rr
  import arb_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int HOLD_MAX = 4
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Req1,
  input  logic [WIDTH-1:0] Data1,
  output logic             Ack1,
  input  logic             Req2,
  input  logic [WIDTH-1:0] Data2,
  output logic             Ack2,
  output logic             OutValid,
  output logic [WIDTH-1:0] OutData,
  input  logic             OutReady,
  output logic             Select,
  output logic             Grant1,
  output logic             Grant2
);

  localparam int              CNT_W    = $clog2(HOLD_MAX) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

  state_t           state_p1, state_n;
  logic             sel_p1, sel_n;
  logic             ptr_p1, ptr_n;
  logic [CNT_W-1:0] cnt_p1, cnt_n;

  logic own_req, oth_req, xfer, do_grant, grant_to1;

  always_comb begin
    state_n   = state_p1;
    sel_n     = sel_p1;
    ptr_n     = ptr_p1;
    cnt_n     = cnt_p1;
    do_grant  = 1'b0;
    grant_to1 = 1'b0;
    own_req   = (state_p1 == G1) ? Req1 : Req2;
    oth_req   = (state_p1 == G1) ? Req2 : Req1;
    xfer      = own_req & OutReady;

    unique case (state_p1)
      IDLE: begin
        cnt_n = '0;
        if (Req1 && Req2) begin
          do_grant  = 1'b1;
          grant_to1 = (ptr_p1 == SEL_CH1);
        end else if (Req1 || Req2) begin
          do_grant  = 1'b1;
          grant_to1 = Req1;
        end
      end
      G1, G2: begin
        if (!own_req) begin
          // Holder released the channel: hand over or fall back to idle.
          if (oth_req) begin
            do_grant  = 1'b1;
            grant_to1 = (state_p1 == G2);
          end else begin
            state_n = IDLE;
            cnt_n   = '0;
          end
        end else if (xfer) begin
          if (cnt_p1 == CNT_LAST) begin
            // Hold window exhausted: switch without a bubble if the other
            // side waits, otherwise start a fresh window.
            cnt_n = '0;
            if (oth_req) begin
              do_grant  = 1'b1;
              grant_to1 = (state_p1 == G2);
            end
          end else begin
            cnt_n = cnt_p1 + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (do_grant) begin
      state_n = grant_to1 ? G1 : G2;
      sel_n   = grant_to1 ? SEL_CH1 : SEL_CH2;
      ptr_n   = grant_to1 ? SEL_CH2 : SEL_CH1;
      cnt_n   = '0;
    end
  end

  // Stage p1: arbitration state register
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_p1 <= IDLE;
      sel_p1   <= SEL_CH1;
      ptr_p1   <= SEL_CH1;
      cnt_p1   <= '0;
    end else begin
      state_p1 <= state_n;
      sel_p1   <= sel_n;
      ptr_p1   <= ptr_n;
      cnt_p1   <= cnt_n;
    end
  end

  assign Grant1   = (state_p1 == G1);
  assign Grant2   = (state_p1 == G2);
  assign Select   = sel_p1;
  assign OutValid = (Grant1 & Req1) | (Grant2 & Req2);
  assign Ack1     = Grant1 & Req1 & OutReady;
  assign Ack2     = Grant2 & Req2 & OutReady;

  for (genvar i = 0; i < WIDTH; i++) begin : g_mux
    mux_2cross1 u_mux (
      .Input1 (Data1[i]),
      .Input2 (Data2[i]),
      .Select (sel_p1),
      .Out    (OutData[i])
    );
  end

endmodule

// File: tb/tb_arb_2cross1_rr.sv
// Testbench for arb_2cross1_rr: directed scenarios plus randomized traffic
// compared against a behavioural model of the arbitration rules.
module tb_arb_2cross1_rr;

  localparam int WIDTH = 8;
  localparam int HOLD  = 4;

  logic             Clock = 1'b0;
  logic             Reset_n;
  logic             Req1, Req2, OutReady;
  logic [WIDTH-1:0] Data1, Data2;
  logic             Ack1, Ack2, OutValid, Select, Grant1, Grant2;
  logic [WIDTH-1:0] OutData;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 Clock = ~Clock;

  arb_2cross1_rr #(.WIDTH(WIDTH), .HOLD_MAX(HOLD)) dut (
    .Clock    (Clock),
    .Reset_n  (Reset_n),
    .Req1     (Req1),
    .Data1    (Data1),
    .Ack1     (Ack1),
    .Req2     (Req2),
    .Data2    (Data2),
    .Ack2     (Ack2),
    .OutValid (OutValid),
    .OutData  (OutData),
    .OutReady (OutReady),
    .Select   (Select),
    .Grant1   (Grant1),
    .Grant2   (Grant2)
  );

  // Behavioural model: who owns the channel (0 = nobody), beats delivered
  // in the current tenure, whose turn it is on a tie, and the mux side.
  int m_owner = 0;
  int m_beats = 0;
  int m_turn  = 1;
  bit m_sel1  = 1'b1;

  task automatic m_give(input int ch);
    m_owner = ch;
    m_beats = 0;
    m_turn  = 3 - ch;
    m_sel1  = (ch == 1);
  endtask

  always @(posedge Clock or negedge Reset_n) begin : model
    bit holder_req, other_req;
    if (!Reset_n) begin
      m_owner = 0; m_beats = 0; m_turn = 1; m_sel1 = 1'b1;
    end else if (m_owner == 0) begin
      if (Req1 && Req2) m_give(m_turn);
      else if (Req1)    m_give(1);
      else if (Req2)    m_give(2);
    end else begin
      holder_req = (m_owner == 1) ? Req1 : Req2;
      other_req  = (m_owner == 1) ? Req2 : Req1;
      if (!holder_req) begin
        if (other_req) m_give(3 - m_owner);
        else begin m_owner = 0; m_beats = 0; end
      end else if (OutReady) begin
        m_beats++;
        if (m_beats == HOLD) begin
          m_beats = 0;
          if (other_req) m_give(3 - m_owner);
        end
      end
    end
  end

  task automatic do_reset(input bit r1, input bit r2, input bit rdy,
                          input logic [WIDTH-1:0] d1, input logic [WIDTH-1:0] d2);
    Reset_n = 1'b0;
    Req1 = r1; Req2 = r2; OutReady = rdy; Data1 = d1; Data2 = d2;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [5:0]  got6;
    logic [12:0] got, exp;
    Reset_n = 1'b0;
    Req1 = 1; Req2 = 1; OutReady = 1; Data1 = 8'h11; Data2 = 8'h22;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    got6 = {Grant1, Grant2, OutValid, Ack1, Ack2, Select};
    n_chk++;
    if (got6 !== 6'b000001) $display("FAIL reset_outputs got=%b exp=%b", got6, 6'b000001);
    else n_pass++;
    Reset_n = 1'b1;
    @(posedge Clock); #1;
    @(negedge Clock);
    got = {Grant1, Grant2, Select, OutValid, Ack1, OutData};
    exp = {1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11};
    n_chk++;
    if (got !== exp) $display("FAIL reset_first_grant got=%h exp=%h", got, exp);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [13:0] got, exp;
    bit a1;
    do_reset(1, 1, 1, 8'h00, 8'h00);
    for (int i = 0; i < 24; i++) begin
      @(posedge Clock); #1;
      Data1 = WIDTH'($urandom); Data2 = WIDTH'($urandom);
      @(negedge Clock);
      a1  = ((i / HOLD) % 2) == 0;
      got = {OutValid, Ack1, Ack2, Grant1, Grant2, Select, OutData};
      exp = {1'b1, a1, !a1, a1, !a1, a1, a1 ? Data1 : Data2};
      n_chk++;
      if (got !== exp) $display("FAIL round_robin[%0d] got=%h exp=%h", i, got, exp);
      else n_pass++;
    end
  endtask

  task automatic test_single_req2();
    logic [11:0] got, exp;
    do_reset(0, 1, 1, 8'h00, 8'hA5);
    exp = {1'b0, 1'b1, 1'b0, 1'b1, 8'hA5};
    for (int i = 0; i < 8; i++) begin
      @(posedge Clock); #1;
      @(negedge Clock);
      got = {Grant1, Grant2, Select, Ack2, OutData};
      n_chk++;
      if (got !== exp) $display("FAIL single_req2[%0d] got=%h exp=%h", i, got, exp);
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    logic [10:0] got, exp;
    do_reset(1, 0, 1, 8'h3C, 8'h00);
    @(posedge Clock); #1;
    @(negedge Clock);
    n_chk++;
    if ({Grant1, Ack1} !== 2'b11) $display("FAIL stall_first_beat got=%b exp=11", {Grant1, Ack1});
    else n_pass++;
    @(posedge Clock); #1;
    OutReady = 0;
    exp = {1'b1, 1'b1, 1'b0, 8'h3C};
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      got = {Grant1, OutValid, Ack1, OutData};
      n_chk++;
      if (got !== exp) $display("FAIL stall_hold[%0d] got=%h exp=%h", i, got, exp);
      else n_pass++;
      @(posedge Clock); #1;
    end
    OutReady = 1;
    @(negedge Clock);
    n_chk++;
    if ({Grant1, Ack1, OutData} !== {2'b11, 8'h3C})
      $display("FAIL stall_release got=%h exp=%h", {Grant1, Ack1, OutData}, {2'b11, 8'h3C});
    else n_pass++;
  endtask

  task automatic test_drop_switch();
    do_reset(1, 1, 1, 8'h12, 8'h34);
    for (int i = 0; i < 2; i++) begin
      @(posedge Clock); #1;
      @(negedge Clock);
      n_chk++;
      if ({Grant1, Ack1} !== 2'b11) $display("FAIL drop_beat1[%0d] got=%b exp=11", i, {Grant1, Ack1});
      else n_pass++;
    end
    @(posedge Clock); #1;
    Req1 = 0;
    @(negedge Clock);
    n_chk++;
    if ({Grant1, OutValid, Ack1} !== 3'b100)
      $display("FAIL drop_idle_beat got=%b exp=100", {Grant1, OutValid, Ack1});
    else n_pass++;
    @(posedge Clock); #1;
    Req1 = 1;
    // A fresh window on channel 2 must give a full HOLD beats.
    for (int i = 0; i < HOLD; i++) begin
      @(negedge Clock);
      n_chk++;
      if ({Grant2, Ack2, Select} !== 3'b110)
        $display("FAIL drop_switch_g2[%0d] got=%b exp=110", i, {Grant2, Ack2, Select});
      else n_pass++;
      @(posedge Clock); #1;
    end
    @(negedge Clock);
    n_chk++;
    if ({Grant1, Ack1} !== 2'b11) $display("FAIL drop_back_g1 got=%b exp=11", {Grant1, Ack1});
    else n_pass++;
  endtask

  task automatic test_pointer();
    do_reset(1, 0, 1, 8'h01, 8'h02);
    @(posedge Clock); #1;
    Req1 = 0;
    @(negedge Clock);
    n_chk++;
    if ({Grant1, OutValid} !== 2'b10) $display("FAIL ptr_release got=%b exp=10", {Grant1, OutValid});
    else n_pass++;
    @(posedge Clock); #1;
    Req1 = 1; Req2 = 1;
    @(negedge Clock);
    n_chk++;
    if ({Grant1, Grant2, Select, OutValid} !== 4'b0010)
      $display("FAIL ptr_idle_sel1 got=%b exp=0010", {Grant1, Grant2, Select, OutValid});
    else n_pass++;
    @(posedge Clock); #1;
    @(negedge Clock);
    n_chk++;
    if ({Grant1, Grant2, Ack2} !== 3'b011) $display("FAIL ptr_tie_to_ch2 got=%b exp=011", {Grant1, Grant2, Ack2});
    else n_pass++;
    @(posedge Clock); #1;
    Req1 = 0; Req2 = 0;
    @(posedge Clock); #1;
    Req1 = 1; Req2 = 1;
    @(negedge Clock);
    n_chk++;
    if ({Grant1, Grant2, Select} !== 3'b000) $display("FAIL ptr_idle_sel0 got=%b exp=000", {Grant1, Grant2, Select});
    else n_pass++;
    @(posedge Clock); #1;
    @(negedge Clock);
    n_chk++;
    if ({Grant1, Grant2, Ack1} !== 3'b101) $display("FAIL ptr_tie_to_ch1 got=%b exp=101", {Grant1, Grant2, Ack1});
    else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset(0, 1, 1, 8'h00, 8'h5A);
    @(posedge Clock); #1;
    @(negedge Clock);
    n_chk++;
    if ({Grant2, Ack2} !== 2'b11) $display("FAIL areset_pre got=%b exp=11", {Grant2, Ack2});
    else n_pass++;
    @(posedge Clock); #3;
    Reset_n = 0;
    #1;
    n_chk++;
    if ({Grant1, Grant2, Ack2, OutValid, Select} !== 5'b00001)
      $display("FAIL areset_clear got=%b exp=00001", {Grant1, Grant2, Ack2, OutValid, Select});
    else n_pass++;
    Req1 = 1; Req2 = 1;
    @(negedge Clock);
    Reset_n = 1;
    @(posedge Clock); #1;
    @(negedge Clock);
    n_chk++;
    if ({Grant1, Grant2, Ack1, Select} !== 4'b1011)
      $display("FAIL areset_restart got=%b exp=1011", {Grant1, Grant2, Ack1, Select});
    else n_pass++;
  endtask

  task automatic test_random();
    logic [13:0] got, exp;
    bit e_g1, e_g2, hold1, hold2;
    do_reset(1'($urandom), 1'($urandom), 1, WIDTH'($urandom), WIDTH'($urandom));
    hold1 = 0; hold2 = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge Clock); #1;
      // A stalled beat stays presented unchanged until it is accepted.
      if (!hold1) begin Req1 = ($urandom_range(0, 3) != 0); Data1 = WIDTH'($urandom); end
      if (!hold2) begin Req2 = ($urandom_range(0, 3) != 0); Data2 = WIDTH'($urandom); end
      OutReady = ($urandom_range(0, 3) != 0);
      @(negedge Clock);
      e_g1 = (m_owner == 1);
      e_g2 = (m_owner == 2);
      exp = {e_g1, e_g2, m_sel1, (e_g1 && Req1) || (e_g2 && Req2),
             e_g1 && Req1 && OutReady, e_g2 && Req2 && OutReady,
             m_sel1 ? Data1 : Data2};
      got = {Grant1, Grant2, Select, OutValid, Ack1, Ack2, OutData};
      n_chk++;
      if (got !== exp) $display("FAIL random[%0d] got=%h exp=%h", i, got, exp);
      else n_pass++;
      hold1 = e_g1 && Req1 && !OutReady;
      hold2 = e_g2 && Req2 && !OutReady;
    end
  endtask

  initial begin
    Reset_n = 0; Req1 = 0; Req2 = 0; OutReady = 0; Data1 = '0; Data2 = '0;
    test_reset();
    test_round_robin();
    test_single_req2();
    test_stall();
    test_drop_switch();
    test_pointer();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
